// File: rtl/riscv_soc_top.sv
package riscv_pkg;
    localparam logic [31:0] MMIO_PRINT_ADDR = 32'h1000_0000;
    localparam logic [31:0] MMIO_DONE_ADDR  = 32'h1000_0004;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
endpackage

module riscv_core
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_n_rst,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic [31:0] i_dmem_rdata
);
    logic [31:0] r_pc;
    logic [31:0] r_regs [32];

    logic        memory_write_enable;
    logic [31:0] memory_address;
    logic [31:0] memory_write_data;

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [31:0] w_rs1_val, w_rs2_val;
    logic [31:0] w_alu_b, w_alu;
    logic [4:0]  w_shamt;
    logic        w_taken;
    logic        w_is_store;
    logic        w_rd_we;
    logic [31:0] w_rd_data;
    logic [31:0] w_next_pc;
    logic        w_halted;

    assign w_instr  = i_imem_rdata;
    assign w_opcode = w_instr[6:0];
    assign w_rd     = w_instr[11:7];
    assign w_funct3 = w_instr[14:12];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                      w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                      w_instr[20], w_instr[30:21], 1'b0};

    assign w_rs1_val = r_regs[w_rs1];
    assign w_rs2_val = r_regs[w_rs2];

    assign w_alu_b = (w_opcode == OPC_OP) ? w_rs2_val : w_imm_i;
    assign w_shamt = w_alu_b[4:0];

    always_comb begin
        w_alu = w_rs1_val + w_alu_b;
        case (w_funct3)
            3'b000: w_alu = (w_opcode == OPC_OP && w_instr[30]) ?
                            w_rs1_val - w_alu_b : w_rs1_val + w_alu_b;
            3'b001: w_alu = w_rs1_val << w_shamt;
            3'b010: w_alu = {31'b0, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'b011: w_alu = {31'b0, w_rs1_val < w_alu_b};
            3'b100: w_alu = w_rs1_val ^ w_alu_b;
            3'b101: w_alu = w_instr[30] ? 32'($signed(w_rs1_val) >>> w_shamt) :
                            w_rs1_val >> w_shamt;
            3'b110: w_alu = w_rs1_val | w_alu_b;
            3'b111: w_alu = w_rs1_val & w_alu_b;
            default: w_alu = w_rs1_val + w_alu_b;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000: w_taken = (w_rs1_val == w_rs2_val);
            3'b001: w_taken = (w_rs1_val != w_rs2_val);
            3'b100: w_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101: w_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110: w_taken = (w_rs1_val <  w_rs2_val);
            3'b111: w_taken = (w_rs1_val >= w_rs2_val);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_pc  = r_pc + 32'd4;
        w_rd_we    = 1'b0;
        w_rd_data  = w_alu;
        w_is_store = 1'b0;
        case (w_opcode)
            OPC_LUI:   begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
            OPC_AUIPC: begin w_rd_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
            OPC_JAL: begin
                w_rd_we   = 1'b1;
                w_rd_data = r_pc + 32'd4;
                w_next_pc = r_pc + w_imm_j;
            end
            OPC_JALR: begin
                w_rd_we   = 1'b1;
                w_rd_data = r_pc + 32'd4;
                w_next_pc = (w_rs1_val + w_imm_i) & ~32'd1;
            end
            OPC_BRANCH: if (w_taken) w_next_pc = r_pc + w_imm_b;
            OPC_LOAD:  begin w_rd_we = 1'b1; w_rd_data = i_dmem_rdata; end
            OPC_STORE: w_is_store = 1'b1;
            OPC_OPIMM, OPC_OP: w_rd_we = 1'b1;
            default: ;
        endcase
    end

    assign memory_address      = w_rs1_val + (w_is_store ? w_imm_s : w_imm_i);
    assign memory_write_data   = w_rs2_val;
    assign memory_write_enable = w_is_store & i_n_rst & ~w_halted;

`ifdef RISCV_DONE_HALT_EN
    logic r_halted;
    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst)
            r_halted <= 1'b0;
        else if (memory_write_enable && memory_address == MMIO_DONE_ADDR)
            r_halted <= 1'b1;
    end
    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_n_rst) begin
        if (!i_n_rst) begin
            r_pc <= RESET_PC;
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (!w_halted) begin
            r_pc <= w_next_pc;
            if (w_rd_we && w_rd != 5'd0) r_regs[w_rd] <= w_rd_data;
        end
    end

    assign o_imem_addr  = r_pc;
    assign o_dmem_we    = memory_write_enable;
    assign o_dmem_addr  = memory_address;
    assign o_dmem_wdata = memory_write_data;
endmodule

module riscv_soc_top
    import riscv_pkg::*;
#(
    parameter int          MEM_WORDS = 4096,
    parameter string       MEM_FILE  = "program.hex",
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic n_rst
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] r_mem [MEM_WORDS];

    logic [31:0] w_imem_addr, w_imem_rdata;
    logic        w_dmem_we;
    logic [31:0] w_dmem_addr, w_dmem_wdata, w_dmem_rdata;
    logic        w_mmio;
    logic [AW-1:0] w_didx;
    logic        w_unused;

    riscv_core #(.RESET_PC(RESET_PC)) cpu (
        .i_clk        (clk),
        .i_n_rst      (n_rst),
        .o_imem_addr  (w_imem_addr),
        .i_imem_rdata (w_imem_rdata),
        .o_dmem_we    (w_dmem_we),
        .o_dmem_addr  (w_dmem_addr),
        .o_dmem_wdata (w_dmem_wdata),
        .i_dmem_rdata (w_dmem_rdata)
    );

    assign w_didx       = w_dmem_addr[AW+1:2];
    assign w_mmio       = (w_dmem_addr == MMIO_PRINT_ADDR) ||
                          (w_dmem_addr == MMIO_DONE_ADDR);
    assign w_imem_rdata = r_mem[w_imem_addr[AW+1:2]];
    assign w_dmem_rdata = w_mmio ? 32'h0 : r_mem[w_didx];
    assign w_unused     = ^{w_imem_addr[31:AW+2], w_imem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (w_dmem_we && !w_mmio) r_mem[w_didx] <= w_dmem_wdata;
    end
endmodule

// File: tb/tb_riscv_soc_top.sv
module tb_riscv_soc_top;
    localparam logic [31:0] PRINT = 32'h1000_0000;
    localparam logic [31:0] DONE  = 32'h1000_0004;

    logic clk = 1'b0;
    logic n_rst;
    int   total = 0;
    int   bad = 0;
    logic [31:0] q[$];
    logic [31:0] prog[$];
    bit   sb_on = 1'b0;
    bit   done_seen = 1'b0;
    int   done_cyc = 0;
    int   cyc = 0;

    riscv_soc_top #(.MEM_FILE("")) dut (.clk(clk), .n_rst(n_rst));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b000, rd, 7'h13);
    endfunction
    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return enc_i(imm, rs1, 3'b010, rd, 7'h03);
    endfunction
    function automatic logic [31:0] srai(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] sh);
        return enc_i({7'b0100000, sh}, rs1, 3'b101, rd, 7'h13);
    endfunction
    function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'h37};
    endfunction
    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] bne(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    task automatic load_prog();
        foreach (prog[i]) dut.r_mem[i] = prog[i];
    endtask

    // Wait (bounded) until every queued print was seen and, if asked, done.
    task automatic wait_drain(input string tag, input int budget, input bit need_done);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (q.size() == 0 && (done_seen || !need_done)) begin ok = 1'b1; break; end
        end
        chk(tag, {31'b0, ok}, 32'd1);
    endtask

    // Bus monitor / scoreboard consumer, sampled mid-cycle.
    always @(negedge clk) begin
        if (!n_rst) begin
            cyc = 0;
            chk("rst_we", {31'b0, dut.cpu.memory_write_enable}, 32'd0);
            chk("rst_pc", dut.cpu.r_pc, 32'h0);
        end else begin
            cyc++;
            if (dut.cpu.memory_write_enable && dut.cpu.memory_address == PRINT && sb_on) begin
                if (q.size() == 0) chk("print_unexpected", 32'(q.size()), 32'd1);
                else chk("print", dut.cpu.memory_write_data, q.pop_front());
            end
            if (dut.cpu.memory_write_enable && dut.cpu.memory_address == DONE && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
            end
        end
    end

    initial begin
        n_rst = 1'b0;
        #1;
        // Program A: directed ALU / memory / control-flow checks.
        prog = {};
        prog.push_back(addi(5'd1, 5'd0, 12'd42));            // 0
        prog.push_back(lui(5'd5, 20'h10000));                // 1
        prog.push_back(sw(5'd1, 5'd5, 12'd0));               // 2 -> 42
        prog.push_back(addi(5'd0, 5'd0, 12'd5));             // 3
        prog.push_back(sw(5'd0, 5'd5, 12'd0));               // 4 -> 0
        prog.push_back(lui(5'd2, 20'hFFFFF));                // 5
        prog.push_back(srai(5'd3, 5'd2, 5'd4));              // 6
        prog.push_back(sw(5'd3, 5'd5, 12'd0));               // 7 -> FFFFFF00
        prog.push_back(lui(5'd6, 20'hDEADC));                // 8
        prog.push_back(addi(5'd6, 5'd6, 12'hEEF));           // 9 x6=DEADBEEF
        prog.push_back(addi(5'd7, 5'd0, 12'h100));           // 10
        prog.push_back(sw(5'd6, 5'd7, 12'd0));               // 11
        prog.push_back(lw(5'd8, 5'd7, 12'd0));               // 12
        prog.push_back(sw(5'd8, 5'd5, 12'd0));               // 13 -> DEADBEEF
        prog.push_back(lw(5'd9, 5'd5, 12'd0));               // 14
        prog.push_back(sw(5'd9, 5'd5, 12'd0));               // 15 -> 0
        prog.push_back(addi(5'd10, 5'd0, 12'd0));            // 16
        prog.push_back(addi(5'd11, 5'd0, 12'd1));            // 17
        prog.push_back(addi(5'd12, 5'd0, 12'd11));           // 18
        prog.push_back(rtype(7'h00, 5'd11, 5'd10, 3'b000, 5'd10)); // 19 add
        prog.push_back(addi(5'd11, 5'd11, 12'd1));           // 20
        prog.push_back(bne(5'd11, 5'd12, 13'h1FF8));         // 21 -> 19
        prog.push_back(sw(5'd10, 5'd5, 12'd0));              // 22 -> 55
        prog.push_back(rtype(7'h20, 5'd11, 5'd0, 3'b000, 5'd13));  // 23 sub -> FFFFFFF5
        prog.push_back(rtype(7'h00, 5'd0, 5'd13, 3'b010, 5'd14));  // 24 slt -> 1
        prog.push_back(rtype(7'h00, 5'd0, 5'd13, 3'b011, 5'd15));  // 25 sltu -> 0
        prog.push_back(rtype(7'h20, 5'd14, 5'd13, 3'b101, 5'd16)); // 26 sra -> FFFFFFFA
        prog.push_back(sw(5'd16, 5'd5, 12'd0));              // 27 -> FFFFFFFA
        prog.push_back(jal(5'd1, 21'd8));                    // 28 -> 30, x1=0x74
        prog.push_back(sw(5'd0, 5'd5, 12'd0));               // 29 skipped
        prog.push_back(sw(5'd1, 5'd5, 12'd0));               // 30 -> 74
        prog.push_back(sw(5'd0, 5'd5, 12'd4));               // 31 done
        prog.push_back(addi(5'd20, 5'd0, 12'd77));           // 32
        prog.push_back(sw(5'd20, 5'd5, 12'd0));              // 33 -> 77 unless halted
        prog.push_back(jal(5'd0, 21'd0));                    // 34
        load_prog();
        q = {32'd42, 32'd0, 32'hFFFF_FF00, 32'hDEAD_BEEF, 32'd0, 32'd55,
             32'hFFFF_FFFA, 32'h0000_0074};
`ifndef RISCV_DONE_HALT_EN
        q.push_back(32'd77);
`endif
        sb_on = 1'b1;
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;
        wait_drain("progA_drain", 200, 1'b1);
        chk("done_within_100", {31'b0, done_seen && done_cyc <= 100}, 32'd1);
`ifdef RISCV_DONE_HALT_EN
        for (int i = 0; i < 50; i++) begin
            chk("halt_we", {31'b0, dut.cpu.memory_write_enable}, 32'd0);
            chk("halt_pc", dut.cpu.r_pc, 32'd128);
            @(posedge clk); #2;
        end
`endif

        // Program B: endless counting print loop, reset mid-loop.
        n_rst = 1'b0;
        sb_on = 1'b0;
        done_seen = 1'b0;
        q = {};
        prog = {};
        prog.push_back(lui(5'd5, 20'h10000));
        prog.push_back(addi(5'd1, 5'd1, 12'd1));
        prog.push_back(sw(5'd1, 5'd5, 12'd0));
        prog.push_back(jal(5'd0, 21'h1FFFF8));
        load_prog();
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;
        for (int v = 1; v <= 5; v++) q.push_back(32'(v));
        sb_on = 1'b1;
        wait_drain("progB_first", 100, 1'b0);
        sb_on = 1'b0;
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk("rst_x1_zero", dut.cpu.r_regs[1], 32'd0);
        chk("rst_x5_zero", dut.cpu.r_regs[5], 32'd0);
        chk("ram_retained", dut.r_mem[64], 32'hDEAD_BEEF);
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;
        for (int v = 1; v <= 3; v++) q.push_back(32'(v));
        sb_on = 1'b1;
        wait_drain("progB_restart", 100, 1'b0);
        sb_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
